// File: rtl/apu_pkg.sv
// -----------------------------------------------------------------------------
// apu_pkg
// Shared types and constants for the APU frame sequencer.
//   fs_step_t      : 3-bit frame sequencer step (0-7)
//   FS_LEN_MASK    : steps that clock the length counters (bit index = step)
//   FS_SWEEP_MASK  : steps that clock the ch1 sweep
//   FS_ENV_MASK    : steps that clock the envelopes
// -----------------------------------------------------------------------------
package apu_pkg;

  typedef logic [2:0] fs_step_t;

  localparam logic [7:0] FS_LEN_MASK   = 8'b0101_0101;
  localparam logic [7:0] FS_SWEEP_MASK = 8'b0100_0100;
  localparam logic [7:0] FS_ENV_MASK   = 8'b1000_0000;

endpackage

// File: rtl/apu_ce_div.sv
// -----------------------------------------------------------------------------
// apu_ce_div
// Free-running 2-bit divider that derives the 2 MHz and 1 MHz clock enables
// from the 4 MHz APU clock.
// Ports:
//   apuv_4mhz  in  : APU clock
//   apu_reset  in  : synchronous active-high reset (APU powered off)
//   ce_2mhz    out : high every 2nd cycle (ce_cnt[0])
//   ce_1mhz    out : high every 4th cycle (ce_cnt == 3)
// -----------------------------------------------------------------------------
module apu_ce_div (
  input  logic apuv_4mhz,
  input  logic apu_reset,
  output logic ce_2mhz,
  output logic ce_1mhz
);

  logic [1:0] ce_cnt;

  always_ff @(posedge apuv_4mhz) begin
    if (apu_reset) begin
      ce_cnt <= 2'd0;
    end else begin
      ce_cnt <= ce_cnt + 2'd1;
    end
  end

  // Decoded straight from the counter so both enables are 0 right after reset
  // and rise after the 1st and 3rd released edges respectively.
  assign ce_2mhz = ce_cnt[0];
  assign ce_1mhz = (ce_cnt == 2'd3);

endmodule

// File: rtl/apu_frame_sequencer.sv
// -----------------------------------------------------------------------------
// apu_frame_sequencer
// Divides the 512 Hz DIV event (falling edge of DIV bit 4) into the length,
// sweep and envelope ticks for channels 1-4, and provides the 2 MHz / 1 MHz
// clock enables.
// Optional feature: define APU_FS_TESTMODE_EN to add the t1_nt2 test input,
// which steps the sequencer once per ce_1mhz instead of on DIV events.
// Ports:
//   apuv_4mhz  in     : APU clock, all state updates on its rising edge
//   apu_reset  in     : synchronous active-high reset (NR52 power off)
//   div_bit    in     : DIV bit 4 level; each falling edge is one event
//   t1_nt2     in     : test mode select (only with APU_FS_TESTMODE_EN)
//   ce_2mhz    out    : clock enable, every 2nd cycle
//   ce_1mhz    out    : clock enable, every 4th cycle
//   len_tick   out    : 1-cycle pulse, length counters (steps 0,2,4,6)
//   sweep_tick out    : 1-cycle pulse, ch1 sweep (steps 2,6)
//   env_tick   out    : 1-cycle pulse, envelopes (step 7)
//   fs_step    out[3] : current step
//   len_half   out    : next step will not clock length
// -----------------------------------------------------------------------------
module apu_frame_sequencer
  import apu_pkg::*;
(
  input  logic     apuv_4mhz,
  input  logic     apu_reset,
  input  logic     div_bit,
`ifdef APU_FS_TESTMODE_EN
  input  logic     t1_nt2,
`endif
  output logic     ce_2mhz,
  output logic     ce_1mhz,
  output logic     len_tick,
  output logic     sweep_tick,
  output logic     env_tick,
  output fs_step_t fs_step,
  output logic     len_half
);

  logic div_q;
  logic fs_ev;

  apu_ce_div u_ce_div (
    .apuv_4mhz (apuv_4mhz),
    .apu_reset (apu_reset),
    .ce_2mhz   (ce_2mhz),
    .ce_1mhz   (ce_1mhz)
  );

`ifdef APU_FS_TESTMODE_EN
  // In test mode div_q still follows div_bit, so dropping t1_nt2 while
  // div_bit is low does not look like a fresh falling edge.
  assign fs_ev = t1_nt2 ? ce_1mhz : (div_q & ~div_bit);
`else
  assign fs_ev = div_q & ~div_bit;
`endif

  always_ff @(posedge apuv_4mhz) begin
    // div_q tracks div_bit even in reset so release never produces an edge.
    div_q <= div_bit;
    if (apu_reset) begin
      fs_step    <= '0;
      len_tick   <= 1'b0;
      sweep_tick <= 1'b0;
      env_tick   <= 1'b0;
    end else begin
      // Ticks are decoded from the step value before the advance.
      len_tick   <= fs_ev & FS_LEN_MASK[fs_step];
      sweep_tick <= fs_ev & FS_SWEEP_MASK[fs_step];
      env_tick   <= fs_ev & FS_ENV_MASK[fs_step];
      if (fs_ev) begin
        fs_step <= fs_step + 3'd1;
      end
    end
  end

  assign len_half = fs_step[0];

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tb_apu_frame_sequencer
// Self-checking bench for apu_frame_sequencer. Every cycle the bench model
// pushes the expected outputs to a queue; they are popped and compared 1 time
// unit after the clock edge. A fixed table of expected step/tick values is
// checked after each DIV fall of the main 8-step sequence.
// -----------------------------------------------------------------------------
module tb_apu_frame_sequencer;

  logic       clk;
  logic       apu_reset;
  logic       div_bit;
  logic       t1_nt2;
  logic       ce_2mhz, ce_1mhz;
  logic       len_tick, sweep_tick, env_tick;
  logic [2:0] fs_step;
  logic       len_half;

  apu_frame_sequencer dut (
    .apuv_4mhz  (clk),
    .apu_reset  (apu_reset),
    .div_bit    (div_bit),
`ifdef APU_FS_TESTMODE_EN
    .t1_nt2     (t1_nt2),
`endif
    .ce_2mhz    (ce_2mhz),
    .ce_1mhz    (ce_1mhz),
    .len_tick   (len_tick),
    .sweep_tick (sweep_tick),
    .env_tick   (env_tick),
    .fs_step    (fs_step),
    .len_half   (len_half)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ce2;
    logic       ce1;
    logic       len;
    logic       sweep;
    logic       env;
    logic [2:0] step;
    logic       half;
  } exp_t;

  typedef struct {
    logic [2:0] step_after;
    logic       len;
    logic       sweep;
    logic       env;
  } fall_vec_t;

  exp_t      sb_q[$];
  fall_vec_t fall_tbl[8];

  int n_vec  = 0;
  int n_fail = 0;

  // reference model state
  logic [1:0] m_cnt;
  logic       m_prev;
  logic [2:0] m_step;
  logic       m_len, m_sweep, m_env;
  int         cyc_since_rst;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model one edge with the given inputs and push its prediction.
  task automatic model_edge(input logic r, input logic d, input logic t);
    exp_t e;
    logic ev;
    if (r) begin
      m_cnt = 2'd0; m_step = 3'd0;
      m_len = 1'b0; m_sweep = 1'b0; m_env = 1'b0;
    end else begin
      ev = t ? (m_cnt == 2'd3) : (m_prev && !d);
      m_len   = ev && (m_step inside {3'd0, 3'd2, 3'd4, 3'd6});
      m_sweep = ev && (m_step inside {3'd2, 3'd6});
      m_env   = ev && (m_step == 3'd7);
      if (ev) m_step = m_step + 3'd1;
      m_cnt = m_cnt + 2'd1;
    end
    m_prev = d;
    e.ce2 = m_cnt[0]; e.ce1 = (m_cnt == 2'd3);
    e.len = m_len; e.sweep = m_sweep; e.env = m_env;
    e.step = m_step; e.half = m_step[0];
    sb_q.push_back(e);
  endtask

  task automatic cyc(input logic r, input logic d);
    exp_t e;
    apu_reset = r;
    div_bit   = d;
    model_edge(r, d, t1_nt2);
    @(posedge clk);
    #1;
    cyc_since_rst = r ? 0 : cyc_since_rst + 1;
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
    end else begin
      e = sb_q.pop_front();
      chk("ce_2mhz",    int'(ce_2mhz),    int'(e.ce2));
      chk("ce_1mhz",    int'(ce_1mhz),    int'(e.ce1));
      chk("len_tick",   int'(len_tick),   int'(e.len));
      chk("sweep_tick", int'(sweep_tick), int'(e.sweep));
      chk("env_tick",   int'(env_tick),   int'(e.env));
      chk("fs_step",    int'(fs_step),    int'(e.step));
      chk("len_half",   int'(len_half),   int'(e.half));
    end
  endtask

  // One DIV period: 8 cycles high, then fall and 7 more cycles low.
  task automatic div_period(output logic [2:0] s, output logic l, output logic sw, output logic en);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    s = fs_step; l = len_tick; sw = sweep_tick; en = env_tick;
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0);
  endtask

  initial begin
    logic [2:0] s;
    logic       l, sw, en;
    int         changes;
    logic [2:0] last;

    fall_tbl[0] = '{3'd1, 1'b1, 1'b0, 1'b0};
    fall_tbl[1] = '{3'd2, 1'b0, 1'b0, 1'b0};
    fall_tbl[2] = '{3'd3, 1'b1, 1'b1, 1'b0};
    fall_tbl[3] = '{3'd4, 1'b0, 1'b0, 1'b0};
    fall_tbl[4] = '{3'd5, 1'b1, 1'b0, 1'b0};
    fall_tbl[5] = '{3'd6, 1'b0, 1'b0, 1'b0};
    fall_tbl[6] = '{3'd7, 1'b1, 1'b1, 1'b0};
    fall_tbl[7] = '{3'd0, 1'b0, 1'b0, 1'b1};

    t1_nt2 = 1'b0; apu_reset = 1'b1; div_bit = 1'b1;
    m_prev = 1'b1; m_cnt = 2'd0; m_step = 3'd0;
    m_len = 1'b0; m_sweep = 1'b0; m_env = 1'b0;
    cyc_since_rst = 0;
    @(negedge clk);

    // reset values
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    chk("rst_fs_step", int'(fs_step), 0);
    chk("rst_ce_2mhz", int'(ce_2mhz), 0);
    chk("rst_ce_1mhz", int'(ce_1mhz), 0);

    // enables for 20 cycles after reset, against the cycle index
    for (int k = 1; k <= 20; k++) begin
      cyc(1'b0, 1'b1);
      chk("ce2_pattern", int'(ce_2mhz), (k % 2 == 1) ? 1 : 0);
      chk("ce1_pattern", int'(ce_1mhz), (k % 4 == 3) ? 1 : 0);
    end

    // 8 DIV falls, 16 cycles apart
    for (int i = 0; i < 8; i++) begin
      div_period(s, l, sw, en);
      chk("tbl_step",  int'(s),  int'(fall_tbl[i].step_after));
      chk("tbl_len",   int'(l),  int'(fall_tbl[i].len));
      chk("tbl_sweep", int'(sw), int'(fall_tbl[i].sweep));
      chk("tbl_env",   int'(en), int'(fall_tbl[i].env));
    end
    chk("wrap_to_0", int'(fs_step), 0);

    // div_bit held high: no ticks, step constant
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1);
    chk("hold_high_step", int'(fs_step), 0);

    // advance to step 6, then reset coincident with the fall
    for (int i = 0; i < 6; i++) div_period(s, l, sw, en);
    chk("pre_rst_step6", int'(fs_step), 6);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b0);
    chk("rst_drop_len", int'(len_tick), 0);
    chk("rst_step0",    int'(fs_step),  0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0);
    chk("rel_low_nostep", int'(fs_step), 0);
    div_period(s, l, sw, en);
    chk("post_rst_len",  int'(l), 1);
    chk("post_rst_step", int'(s), 1);

    // div_bit high in reset, falls during reset, released low: no step
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0);
    chk("fall_in_rst_ignored", int'(fs_step), 0);

`ifdef APU_FS_TESTMODE_EN
    // test mode: one step per ce_1mhz, div_bit toggling ignored
    changes = 0;
    last = fs_step;
    t1_nt2 = 1'b1;
    for (int i = 0; i < 32; i++) begin
      cyc(1'b0, i[0]);
      if (fs_step != last) changes++;
      last = fs_step;
    end
    chk("tm_step_count", changes, 8);
    t1_nt2 = 1'b0;
    last = fs_step;
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0);
    chk("tm_exit_nostep", int'(fs_step), int'(last));
`else
    changes = 0;
    last = fs_step;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
